// File: rtl/instruction_memory_sync.sv
// instruction_memory_sync
//   Synchronous instruction memory with a registered read port, a loader
//   write port and a three-state output handshake (IDLE / OUT / HOLD).
//
//   Optional feature: define IMEM_PARITY_EN to keep an even-parity bit per
//   stored word; a parity mismatch on read is reported as a fault.
//
// Ports
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous active-high reset
//   req         in   1       fetch request
//   Address     in   32      byte address of the fetch
//   stall       in   1       consumer not ready, hold presented output
//   Instruction out  32      fetched word (registered)
//   valid       out  1       Instruction meaningful this cycle
//   fault       out  1       presented fetch was bad (address / parity)
//   load_en     in   1       loader write strobe
//   load_addr   in   IDX_W   loader word index
//   load_data   in   32      loader write data
//   busy        out  1       loader active, fetches are refused
module instruction_memory_sync #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [31:0]              Address,
  input  logic                     stall,
  output logic [31:0]              Instruction,
  output logic                     valid,
  output logic                     fault,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      r_instr;
  logic             r_fault;

  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_hi_bits;
  logic             w_addr_fault;
  logic             w_read_fault;
  logic [31:0]      w_word;
  logic             w_accept;

  assign busy      = load_en;
  assign w_idx     = Address[IDX_W+1:2];
  assign w_hi_bits = Address >> (IDX_W + 2);
  assign w_word    = r_mem[w_idx];

  assign w_addr_fault = (Address[1:0] != 2'b00) || (w_hi_bits != '0);

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk) begin
    if (load_en && !reset) begin
      r_par[load_addr] <= ^load_data;
    end
  end

  assign w_read_fault = w_addr_fault || ((^w_word) != r_par[w_idx]);
`else
  assign w_read_fault = w_addr_fault;
`endif

  // Memory is never cleared; writes are only blocked while reset is high.
  always_ff @(posedge clk) begin
    if (load_en && !reset) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // A stall in OUT freezes the presented word, so no fetch is taken then;
  // a loader write always wins over a fetch in the same cycle.
  assign w_accept = req && !load_en &&
                    ((r_state == S_IDLE) || ((r_state == S_OUT) && !stall));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_OUT : S_IDLE;
      S_OUT: begin
        if (stall)         w_next = S_HOLD;
        else if (w_accept) w_next = S_OUT;
        else               w_next = S_IDLE;
      end
      S_HOLD:  w_next = stall ? S_HOLD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_instr <= NOP_WORD;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_instr <= w_read_fault ? NOP_WORD : w_word;
        r_fault <= w_read_fault;
      end
    end
  end

  assign Instruction = r_instr;
  assign fault       = r_fault;
  assign valid       = (r_state != S_IDLE);

endmodule

// File: tb/tb_instruction_memory_sync.sv
module tb_instruction_memory_sync;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] Address;
  logic        stall;
  logic [31:0] Instruction;
  logic        valid;
  logic        fault;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  instruction_memory_sync #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .Address     (Address),
    .stall       (stall),
    .Instruction (Instruction),
    .valid       (valid),
    .fault       (fault),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        rq;
    logic [31:0] addr;
    logic        st;
    logic        chk_data;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_fault;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_load(input logic [7:0] a, input logic [31:0] d);
    vq.push_back('{1'b1, a, d, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
  endtask

  task automatic add_fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    vq.push_back('{1'b0, 8'h0, 32'h0, 1'b1, a, 1'b0, 1'b1, ei, 1'b1, ef});
  endtask

  task automatic add_idle(input logic ld, input logic [7:0] la, input logic [31:0] d, input logic rq);
    vq.push_back('{ld, la, d, rq, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
  endtask

  task automatic set_in(input logic ld, input logic [7:0] la, input logic [31:0] d,
                        input logic rq, input logic [31:0] a, input logic st);
    load_en   = ld;
    load_addr = la;
    load_data = d;
    req       = rq;
    Address   = a;
    stall     = st;
  endtask

  initial begin
    set_in(1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    #12;
    check("reset_instr", Instruction, NOP);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_fault", {31'b0, fault}, 32'd0);
    tick();
    reset = 1'b0;

    add_load(8'd0, 32'h2004_0005);
    add_load(8'd1, 32'h1111_1111);
    add_load(8'd2, 32'h2222_2222);
    add_load(8'd3, 32'h0A5A_5A5A);
    add_fetch(32'h0000_0000, 32'h2004_0005, 1'b0);
    add_fetch(32'h0000_0004, 32'h1111_1111, 1'b0);
    add_fetch(32'h0000_0002, NOP, 1'b1);
    add_fetch(32'h0000_0400, NOP, 1'b1);
    add_fetch(32'h0000_0008, 32'h2222_2222, 1'b0);
    add_idle(1'b0, 8'h0, 32'h0, 1'b0);
    add_fetch(32'h8000_0000, NOP, 1'b1);
    add_fetch(32'h0000_000C, 32'h0A5A_5A5A, 1'b0);
    add_idle(1'b1, 8'd5, 32'h55AA_00FF, 1'b1);
    add_fetch(32'h0000_0014, 32'h55AA_00FF, 1'b0);
    add_load(8'd255, 32'hFFFF_0001);
    add_fetch(32'h0000_03FC, 32'hFFFF_0001, 1'b0);
    add_fetch(32'h0000_0401, NOP, 1'b1);
    add_idle(1'b0, 8'h0, 32'h0, 1'b0);

    foreach (vq[i]) begin
      set_in(vq[i].ld_en, vq[i].ld_addr, vq[i].ld_data, vq[i].rq, vq[i].addr, vq[i].st);
      tick();
      check($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, vq[i].e_valid});
      if (vq[i].chk_data) begin
        check($sformatf("vec%0d_instr", i), Instruction, vq[i].e_instr);
        check($sformatf("vec%0d_fault", i), {31'b0, fault}, {31'b0, vq[i].e_fault});
      end
    end

    // Stall sequence: word 1 held for three cycles, fetch to 8 dropped.
    set_in(1'b0, 8'h0, 32'h0, 1'b1, 32'h4, 1'b0);
    tick();
    check("hold_first", Instruction, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      set_in(i == 1, 8'd6, 32'h6666_6666, 1'b1, 32'h8, 1'b1);
      tick();
      check($sformatf("hold%0d_instr", i), Instruction, 32'h1111_1111);
      check($sformatf("hold%0d_valid", i), {31'b0, valid}, 32'd1);
      check($sformatf("hold%0d_fault", i), {31'b0, fault}, 32'd0);
    end
    set_in(1'b0, 8'h0, 32'h0, 1'b1, 32'h8, 1'b0);
    tick();
    check("hold_release_valid", {31'b0, valid}, 32'd0);
    set_in(1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    check("hold_dropped_valid", {31'b0, valid}, 32'd0);
    set_in(1'b0, 8'h0, 32'h0, 1'b1, 32'd24, 1'b0);
    tick();
    check("load_in_hold_data", Instruction, 32'h6666_6666);

    // Loader and fetch in the same cycle: loader wins, retry sees new data.
    set_in(1'b1, 8'd7, 32'h7777_7777, 1'b1, 32'd28, 1'b0);
    #1;
    check("busy_high", {31'b0, busy}, 32'd1);
    tick();
    check("collide_valid", {31'b0, valid}, 32'd0);
    set_in(1'b0, 8'h0, 32'h0, 1'b1, 32'd28, 1'b0);
    #1;
    check("busy_low", {31'b0, busy}, 32'd0);
    tick();
    check("retry_instr", Instruction, 32'h7777_7777);
    check("retry_valid", {31'b0, valid}, 32'd1);

    // Reset between edges while in OUT; write during reset is suppressed.
    reset = 1'b1;
    #2;
    check("async_rst_valid", {31'b0, valid}, 32'd0);
    check("async_rst_instr", Instruction, NOP);
    check("async_rst_fault", {31'b0, fault}, 32'd0);
    set_in(1'b1, 8'd0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    tick();
    set_in(1'b0, 8'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_instr", Instruction, 32'h2004_0005);
    check("post_rst_valid", {31'b0, valid}, 32'd1);

    // Reset in HOLD discards the held word.
    set_in(1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    check("rst_hold_pre_valid", {31'b0, valid}, 32'd1);
    reset = 1'b1;
    #2;
    check("rst_hold_valid", {31'b0, valid}, 32'd0);
    check("rst_hold_instr", Instruction, NOP);
    reset = 1'b0;
    set_in(1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    check("rst_hold_after_valid", {31'b0, valid}, 32'd0);

`ifdef IMEM_PARITY_EN
    set_in(1'b1, 8'd9, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    tick();
    set_in(1'b0, 8'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    dut.r_mem[9] = dut.r_mem[9] ^ 32'h0000_0100;
    set_in(1'b0, 8'h0, 32'h0, 1'b1, 32'd36, 1'b0);
    tick();
    check("parity_fault", {31'b0, fault}, 32'd1);
    check("parity_instr", Instruction, NOP);
    check("parity_valid", {31'b0, valid}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory_sync.md
INSTRUCTION_MEMORY_SYNC -- requirements
Module: instruction_memory_sync

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit instruction words; it is a power of two and at least 4.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000, meaning the word returned on fault or after reset.
REQ-003 SHALL have localparam IDX_W = log2(DEPTH), meaning the word-index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, 1 bit: fetch request.
REQ-007 SHALL have port Address, input, 32 bits: byte address of the fetch.
REQ-008 SHALL have port stall, input, 1 bit: consumer not ready; hold the presented output.
REQ-009 SHALL have port Instruction, output, 32 bits: fetched word (registered).
REQ-010 SHALL have port valid, output, 1 bit: Instruction is meaningful this cycle.
REQ-011 SHALL have port fault, output, 1 bit: the presented fetch was bad (address, or parity per REQ-029).
REQ-012 SHALL have port load_en, input, 1 bit: loader write strobe.
REQ-013 SHALL have port load_addr, input, IDX_W bits: loader word index.
REQ-014 SHALL have port load_data, input, 32 bits: loader write data.
REQ-015 SHALL have port busy, output, 1 bit: combinational copy of load_en; a fetch is not accepted while busy is high.

Function
REQ-016 SHALL decode word index = Address[IDX_W+1:2].
REQ-017 SHALL flag a fetch as address-faulted when Address[1:0] != 0, or when any Address bit above IDX_W+1 is nonzero.
REQ-018 SHALL accept a fetch at a rising edge when req=1, busy=0, and the FSM is not in HOLD.
REQ-019 SHALL present an accepted fetch after that same edge (latency 1): Instruction = mem[index] and valid=1; a faulted fetch instead presents Instruction = NOP_WORD with fault=1.
REQ-020 SHALL implement an FSM with states IDLE (valid=0), OUT (valid=1), and HOLD (valid=1, outputs frozen).
REQ-021 SHALL make these FSM transitions:
- IDLE -> OUT on an accepted fetch.
- OUT -> OUT on an accepted fetch with stall=0.
- OUT -> HOLD when stall=1.
- OUT -> IDLE when stall=0 and no fetch is accepted.
- HOLD -> HOLD while stall=1.
- HOLD -> IDLE when stall drops.
REQ-022 SHALL leave Instruction and fault unchanged in HOLD; a req during HOLD is ignored and not queued.
REQ-023 SHALL write load_data to mem[load_addr] on each rising edge with load_en=1; a loader write has priority over a fetch in the same cycle (the fetch is not accepted).
REQ-024 SHALL make a fetch of index k accepted one or more cycles after a write to k return the new data; there is no bypass within the write cycle itself.
REQ-025 SHALL NOT alter the currently presented Instruction when a load occurs in OUT or HOLD.

Reset
REQ-026 SHALL, while reset=1, immediately force Instruction=NOP_WORD, valid=0, fault=0, and state IDLE, independent of clk.
REQ-027 SHALL suppress memory writes at any edge where reset=1 and SHALL NOT clear memory contents; reset asserted mid-HOLD discards the held word.
REQ-028 SHALL, on the first edge after reset deasserts, accept a fetch normally.

Configuration
REQ-029 SHALL, with macro IMEM_PARITY_EN defined, store an even-parity bit per word at load time and check it on read; a mismatch presents NOP_WORD with fault=1.
REQ-030 SHALL, without IMEM_PARITY_EN, store no parity and assert fault only on address faults.

Verification
REQ-031 SHALL cover: load 32'h20040005 at index 0, then fetch Address=0 -> next cycle Instruction=32'h20040005, valid=1, fault=0.
REQ-032 SHALL cover: fetch Address=32'h2 and, with DEPTH=256, Address=32'h400 -> NOP_WORD, valid=1, fault=1 for each.
REQ-033 SHALL cover: fetch Address=4, then hold stall=1 for 3 cycles while req targets 8 -> word 1 held unchanged, then state IDLE; the fetch to 8 is not returned.
REQ-034 SHALL cover: load_en=1 and req=1 in the same cycle -> busy=1, valid=0 next cycle, write committed; a retried fetch returns the new data.
REQ-035 SHALL cover: reset pulsed between clock edges while in OUT -> valid=0 and Instruction=0 immediately, memory contents intact afterwards.
REQ-036 SHALL cover, with IMEM_PARITY_EN defined: the bench forces a single-bit flip in a stored word -> fetch gives fault=1 and Instruction=NOP_WORD.
